// File: rtl/cpu_memory_arbiter.sv
// Instruction-fill / CPU-data arbiter driving one single-ported 16-bit memory
// through a fixed two-stage pipeline. Optional starvation guard: CPU_MEMORY_ARBITER_STARVE_GUARD_EN.
module cpu_memory_arbiter #(
    parameter int ADDRESS_BITS = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] instr_address,
    input  logic                    instr_rd_req,
    output logic                    instr_success,
    output logic [ADDRESS_BITS-1:0] instr_requested_address,
    output logic [15:0]             instr_data,
    output logic                    will_queue,
    input  logic [ADDRESS_BITS-1:0] data_address,
    input  logic                    data_rd_req,
    input  logic                    data_wr_req,
    input  logic [15:0]             data_wr_val,
    input  logic [1:0]              data_wr_mask,
    output logic                    data_success,
    output logic [15:0]             data_rd_val,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic                    mem_wr,
    output logic [15:0]             mem_wr_data,
    output logic [1:0]              mem_wr_mask,
    input  logic [15:0]             mem_rd_data
);

    logic                    data_req_s;
    logic                    forced_s;
    logic                    grant_i_s;
    logic                    grant_d_s;

    logic                    a_instr_r;
    logic                    a_drd_r;
    logic [ADDRESS_BITS-1:0] mem_address_r;
    logic                    mem_wr_r;
    logic [15:0]             mem_wr_data_r;
    logic [1:0]              mem_wr_mask_r;

    logic                    instr_success_r;
    logic [ADDRESS_BITS-1:0] instr_requested_address_r;
    logic                    data_success_r;
    logic                    b_drd_r;

`ifdef CPU_MEMORY_ARBITER_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIMIT_C = 3'(STARVE_LIMIT);
    logic [2:0] starve_cnt_r;

    // Force an instruction grant once the denied streak has reached the limit.
    always_comb begin
        forced_s = instr_rd_req && (starve_cnt_r >= STARVE_LIMIT_C);
    end

    // Count consecutive denied instruction cycles, saturating at the counter maximum.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_r <= 3'd0;
        end else if (grant_i_s) begin
            starve_cnt_r <= 3'd0;
        end else if (instr_rd_req && (starve_cnt_r != 3'd7)) begin
            starve_cnt_r <= starve_cnt_r + 3'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    // Strict data priority: never force an instruction grant.
    always_comb begin
        forced_s = 1'b0;
    end
`endif

    // Grant selection: data wins unless the guard forces the instruction port.
    always_comb begin
        data_req_s = data_rd_req | data_wr_req;
        grant_i_s  = instr_rd_req & (~data_req_s | forced_s) & ~RST;
        grant_d_s  = data_req_s & ~grant_i_s & ~RST;
    end

    assign will_queue = grant_i_s;

    // Stage A: register the grant and drive the memory port; address holds when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_instr_r     <= 1'b0;
            a_drd_r       <= 1'b0;
            mem_wr_r      <= 1'b0;
            mem_address_r <= {ADDRESS_BITS{1'b0}};
            mem_wr_data_r <= 16'h0000;
            mem_wr_mask_r <= 2'b00;
        end else begin
            a_instr_r <= grant_i_s;
            a_drd_r   <= grant_d_s & ~data_wr_req;
            mem_wr_r  <= grant_d_s & data_wr_req;
            if (grant_i_s) begin
                mem_address_r <= instr_address;
            end else if (grant_d_s) begin
                mem_address_r <= data_address;
            end
            if (grant_d_s && data_wr_req) begin
                mem_wr_data_r <= data_wr_val;
                mem_wr_mask_r <= data_wr_mask;
            end
        end
    end

    // Stage B: completion strobes and the echoed instruction address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_success_r           <= 1'b0;
            instr_requested_address_r <= {ADDRESS_BITS{1'b0}};
            data_success_r            <= 1'b0;
            b_drd_r                   <= 1'b0;
        end else begin
            instr_success_r <= a_instr_r;
            data_success_r  <= a_drd_r | mem_wr_r;
            b_drd_r         <= a_drd_r;
            if (a_instr_r) begin
                instr_requested_address_r <= mem_address_r;
            end
        end
    end

    // The memory's own output register supplies the read word in stage B, so it is
    // passed through, gated by the registered strobe so idle/reset outputs read as 0.
    always_comb begin
        if (instr_success_r) begin
            instr_data = mem_rd_data;
        end else begin
            instr_data = 16'h0000;
        end
        if (b_drd_r) begin
            data_rd_val = mem_rd_data;
        end else begin
            data_rd_val = 16'h0000;
        end
    end

    assign instr_success           = instr_success_r;
    assign instr_requested_address = instr_requested_address_r;
    assign data_success            = data_success_r;
    assign mem_address             = mem_address_r;
    assign mem_wr                  = mem_wr_r;
    assign mem_wr_data             = mem_wr_data_r;
    assign mem_wr_mask             = mem_wr_mask_r;

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Self-checking bench for cpu_memory_arbiter: behavioural memory, grant-order
// reference model with per-cycle expectation tables, directed and random stimulus.
module tb_cpu_memory_arbiter;
    localparam int AB = 15;
    localparam int LIMIT = 4;
    localparam int DEPTH = 4096;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AB-1:0] instr_address;
    logic          instr_rd_req;
    logic          instr_success;
    logic [AB-1:0] instr_requested_address;
    logic [15:0]   instr_data;
    logic          will_queue;
    logic [AB-1:0] data_address;
    logic          data_rd_req;
    logic          data_wr_req;
    logic [15:0]   data_wr_val;
    logic [1:0]    data_wr_mask;
    logic          data_success;
    logic [15:0]   data_rd_val;
    logic [AB-1:0] mem_address;
    logic          mem_wr;
    logic [15:0]   mem_wr_data;
    logic [1:0]    mem_wr_mask;
    logic [15:0]   mem_rd_data;

    cpu_memory_arbiter #(.ADDRESS_BITS(AB), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .instr_address(instr_address), .instr_rd_req(instr_rd_req),
        .instr_success(instr_success), .instr_requested_address(instr_requested_address),
        .instr_data(instr_data), .will_queue(will_queue),
        .data_address(data_address), .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_wr_val(data_wr_val), .data_wr_mask(data_wr_mask),
        .data_success(data_success), .data_rd_val(data_rd_val),
        .mem_address(mem_address), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .mem_wr_mask(mem_wr_mask), .mem_rd_data(mem_rd_data)
    );

    always #5 CLK = ~CLK;

    // Behavioural synchronous memory: read data registered, byte-masked write.
    logic [15:0] mem [0:32767];
    always @(posedge CLK) begin
        mem_rd_data <= mem[mem_address];
        if (mem_wr) begin
            if (mem_wr_mask[0]) mem[mem_address][7:0]  = mem_wr_data[7:0];
            if (mem_wr_mask[1]) mem[mem_address][15:8] = mem_wr_data[15:8];
        end
    end

    // Reference model state and per-cycle expectation tables.
    logic [15:0] ref_mem [0:32767];
    logic        e_wq [0:DEPTH-1];
    logic        e_mwr [0:DEPTH-1];
    logic [AB-1:0] e_maddr [0:DEPTH-1];
    logic [15:0] e_mwdata [0:DEPTH-1];
    logic [1:0]  e_mwmask [0:DEPTH-1];
    logic        e_isucc [0:DEPTH-1];
    logic [AB-1:0] e_iaddr [0:DEPTH-1];
    logic [15:0] e_idata [0:DEPTH-1];
    logic        e_dsucc [0:DEPTH-1];
    logic        e_drd [0:DEPTH-1];
    logic [15:0] e_dval [0:DEPTH-1];
    logic [AB-1:0] last_addr;
    int          streak;
    int          cyc = 0;
    int          chk_start = 1 << 30;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic preload(input logic [AB-1:0] a, input logic [15:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Apply one cycle of inputs and record what the spec says must follow.
    task automatic step(input logic rst, input logic ireq, input logic [AB-1:0] ia,
                        input logic drd, input logic dwr, input logic [AB-1:0] da,
                        input logic [15:0] wv, input logic [1:0] wm);
        logic dreq, forced, gi, gd;
        @(posedge CLK);
        #1;
        cyc++;
        RST = rst; instr_rd_req = ireq; instr_address = ia;
        data_rd_req = drd; data_wr_req = dwr; data_address = da;
        data_wr_val = wv; data_wr_mask = wm;
        if (rst) begin
            if (chk_start > cyc) chk_start = cyc + 1;
            streak = 0;
            last_addr = '0;
            e_wq[cyc] = 1'b0;
            e_mwr[cyc+1] = 1'b0;
            e_maddr[cyc+1] = '0;
            for (int k = 1; k <= 2; k++) begin
                e_isucc[cyc+k] = 1'b0;
                e_dsucc[cyc+k] = 1'b0;
                e_drd[cyc+k] = 1'b0;
            end
        end else begin
            dreq = drd | dwr;
`ifdef CPU_MEMORY_ARBITER_STARVE_GUARD_EN
            forced = ireq && (streak >= LIMIT);
`else
            forced = 1'b0;
`endif
            gi = ireq && (!dreq || forced);
            gd = dreq && !gi;
            if (gi) streak = 0;
            else if (ireq && streak < 7) streak = streak + 1;
            e_wq[cyc] = gi;
            if (gi) last_addr = ia;
            else if (gd) last_addr = da;
            e_maddr[cyc+1] = last_addr;
            e_mwr[cyc+1] = gd && dwr;
            e_isucc[cyc+2] = gi;
            e_iaddr[cyc+2] = ia;
            e_idata[cyc+2] = ref_mem[ia];
            e_dsucc[cyc+2] = gd;
            e_drd[cyc+2] = gd && !dwr;
            e_dval[cyc+2] = ref_mem[da];
            if (gd && dwr) begin
                e_mwdata[cyc+1] = wv;
                e_mwmask[cyc+1] = wm;
                if (wm[0]) ref_mem[da][7:0] = wv[7:0];
                if (wm[1]) ref_mem[da][15:8] = wv[15:8];
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    endtask

    // Compare process: every cycle after reset, DUT outputs against the model tables.
    always @(negedge CLK) begin
        if (cyc >= chk_start) begin
            chk("will_queue", {31'd0, will_queue}, {31'd0, e_wq[cyc]});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_mwr[cyc]});
            chk("mem_address", {17'd0, mem_address}, {17'd0, e_maddr[cyc]});
            if (e_mwr[cyc]) begin
                chk("mem_wr_data", {16'd0, mem_wr_data}, {16'd0, e_mwdata[cyc]});
                chk("mem_wr_mask", {30'd0, mem_wr_mask}, {30'd0, e_mwmask[cyc]});
            end
            chk("instr_success", {31'd0, instr_success}, {31'd0, e_isucc[cyc]});
            if (e_isucc[cyc]) begin
                chk("instr_requested_address", {17'd0, instr_requested_address}, {17'd0, e_iaddr[cyc]});
                chk("instr_data", {16'd0, instr_data}, {16'd0, e_idata[cyc]});
            end
            chk("data_success", {31'd0, data_success}, {31'd0, e_dsucc[cyc]});
            if (e_drd[cyc]) begin
                chk("data_rd_val", {16'd0, data_rd_val}, {16'd0, e_dval[cyc]});
            end
        end
    end

    initial begin
        int first_isucc;
        int n_isucc;
        logic ir, dr, dw, rs;
        int r;
        RST = 1'b1; instr_rd_req = 1'b0; instr_address = '0;
        data_rd_req = 1'b0; data_wr_req = 1'b0; data_address = '0;
        data_wr_val = 16'h0000; data_wr_mask = 2'b00;
        streak = 0; last_addr = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        idle();
        @(negedge CLK);
        chk("reset_mem_address", {17'd0, mem_address}, 32'h0);
        chk("reset_instr_success", {31'd0, instr_success}, 32'h0);

        // Single instruction read
        preload(15'h0123, 16'hBEEF);
        step(1'b0, 1'b1, 15'h0123, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        @(negedge CLK);
        chk("t1_will_queue", {31'd0, will_queue}, 32'h1);
        idle(); idle();
        @(negedge CLK);
        chk("t1_success", {31'd0, instr_success}, 32'h1);
        chk("t1_address", {17'd0, instr_requested_address}, 32'h0123);
        chk("t1_data", {16'd0, instr_data}, 32'hBEEF);

        // Streaming fill of 16 words
        preload(15'h010F, 16'h5A5A);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 15'(16'h0100 + i), 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        idle(); idle();
        @(negedge CLK);
        chk("t2_last_address", {17'd0, instr_requested_address}, 32'h010F);
        chk("t2_last_data", {16'd0, instr_data}, 32'h5A5A);

        // Collision: data wins, held instruction request follows one cycle later
        preload(15'h0200, 16'h1111);
        preload(15'h0300, 16'h3333);
        step(1'b0, 1'b1, 15'h0300, 1'b1, 1'b0, 15'h0200, 16'h0000, 2'b00);
        @(negedge CLK);
        chk("t3_will_queue", {31'd0, will_queue}, 32'h0);
        step(1'b0, 1'b1, 15'h0300, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        idle();
        @(negedge CLK);
        chk("t3_data_success", {31'd0, data_success}, 32'h1);
        chk("t3_data_val", {16'd0, data_rd_val}, 32'h1111);
        chk("t3_no_instr", {31'd0, instr_success}, 32'h0);
        idle();
        @(negedge CLK);
        chk("t3_instr_data", {16'd0, instr_data}, 32'h3333);

        // Masked write then read-back
        preload(15'h0010, 16'h1234);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 15'h0010, 16'hABCD, 2'b01);
        idle(); idle();
        @(negedge CLK);
        chk("t4_write_ack", {31'd0, data_success}, 32'h1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 15'h0010, 16'h0000, 2'b00);
        idle(); idle();
        @(negedge CLK);
        chk("t4_read_val", {16'd0, data_rd_val}, 32'h12CD);

        // Reset mid-flight squashes both reads
        step(1'b0, 1'b1, 15'h0020, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        step(1'b1, 1'b1, 15'h0021, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        @(negedge CLK);
        chk("t5_wq_in_reset", {31'd0, will_queue}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            idle();
            @(negedge CLK);
            chk("t5_no_instr", {31'd0, instr_success}, 32'h0);
            chk("t5_zero_outs", {instr_data, 1'b0, instr_requested_address},
                32'h0);
            chk("t5_zero_mem", {mem_wr, mem_wr_mask, data_success, 12'd0, mem_address},
                32'h0);
        end

        // Starvation: continuous data reads plus a held instruction request
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
        first_isucc = -1;
        n_isucc = 0;
        for (int i = 0; i < 34; i++) begin
            step(1'b0, i < 32, 15'h0041, i < 32, 1'b0, 15'h0040, 16'h0000, 2'b00);
            @(negedge CLK);
            if (instr_success) begin
                n_isucc++;
                if (first_isucc < 0) begin
                    first_isucc = i;
                    chk("t6_data_denied", {31'd0, data_success}, 32'h0);
                end
            end
        end
`ifdef CPU_MEMORY_ARBITER_STARVE_GUARD_EN
        chk("t6_first_forced", first_isucc, 32'd6);
`else
        chk("t6_starved", n_isucc, 32'd0);
`endif

        // Randomized traffic over a small address window
        for (int i = 0; i < 700; i++) begin
            ir = ($urandom_range(0, 99) < 60);
            r = $urandom_range(0, 9);
            dr = (r <= 3) || (r == 6);
            dw = (r == 4) || (r == 5) || (r == 6);
            rs = ($urandom_range(0, 99) == 0);
            step(rs, ir, 15'($urandom_range(0, 63)), dr, dw, 15'($urandom_range(0, 63)),
                 16'($urandom), 2'($urandom_range(0, 3)));
        end
        idle(); idle(); idle();
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_memory_arbiter.md
# cpu_memory_arbiter

- Arbitrates between the instruction-cache fill port and the CPU data (load/store) port.
- Drives one single-ported 16-bit synchronous memory through a fixed two-cycle read pipeline.
- Returns each instruction read with its echoed address and a success strobe, so the instruction cache can write its line directly.
- Provides the `will_queue` look-ahead the cache uses to keep background fills flowing.

## Interface

Parameters:
- `ADDRESS_BITS`, 15: word address width on all ports.
- `STARVE_LIMIT`, 4: consecutive denied instruction cycles before a forced grant (used only with the guard macro).

Ports:
- `CLK`  in  1  sole clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `instr_address`  in  15  instruction fill address.
- `instr_rd_req`  in  1  instruction read request, level-sensitive, sampled every cycle.
- `instr_success`  out  1  instruction read data valid this cycle.
- `instr_requested_address`  out  15  address that belongs to `instr_data`.
- `instr_data`  out  16  instruction word.
- `will_queue`  out  1  combinational: an instruction request presented this cycle will be granted.
- `data_address`  in  15  load/store address.
- `data_rd_req`  in  1  load request.
- `data_wr_req`  in  1  store request.
- `data_wr_val`  in  16  store data.
- `data_wr_mask`  in  2  byte enables, bit 1 = high byte.
- `data_success`  out  1  data access completed this cycle.
- `data_rd_val`  out  16  load data.
- `mem_address`  out  15  memory address (registered).
- `mem_wr`  out  1  memory write strobe (registered).
- `mem_wr_data`  out  16  memory write data.
- `mem_wr_mask`  out  2  memory byte enables.
- `mem_rd_data`  in  16  memory read data, valid the cycle after `mem_address`.

## Operation

Each cycle, at most one grant is issued:
- **Grant D (data):** any `data_rd_req` or `data_wr_req`. Data has priority unless the starvation guard forces I.
- **Grant I (instruction):** `instr_rd_req` with no data request, or a forced grant.
- **No grant:** `mem_wr` = 0 and `mem_address` holds its last value.
- `data_rd_req` and `data_wr_req` asserted together: the write wins; the read is ignored.

Pipeline:
- **Stage A (cycle N+1):** registers the grant, drives `mem_address`, `mem_wr`, `mem_wr_data` and `mem_wr_mask`. Writes complete here.
- **Stage B (cycle N+2):**
  - Instruction reads: `instr_success`=1, `instr_data`=`mem_rd_data`, `instr_requested_address` = the granted address.
  - Data reads: `data_success`=1 and `data_rd_val`=`mem_rd_data`.
  - Writes: `data_success`=1 at N+2.

`will_queue` = `instr_rd_req` & (no data request | forced grant) & !`RST`.

Requesters hold their request until they see `*_success`, or they may drop it. A dropped request that was already granted still completes, and the requester discards the result.

A new grant is accepted every cycle; up to two accesses are in flight.

No reordering: success strobes appear in grant order, exactly two cycles after grant.

Reset:
- Every output and the pipeline registers go to 0; the starvation counter clears.
- Reset mid-operation squashes in-flight accesses: no `*_success` in the cycles after `RST` deasserts until a fresh grant completes.

## Timing

- Read latency is 2 cycles from request sample to success (instruction and data).
- Write acknowledge is 2 cycles; memory is updated at the N+1 edge.
- Throughput is 1 access per cycle.
- `will_queue` is combinational from the request inputs (same cycle).
- All other outputs are registered.
- Back-to-back data requests starve the instruction port indefinitely unless the guard is compiled in.

## Configuration

Macro: `CPU_MEMORY_ARBITER_STARVE_GUARD_EN`.
- **Defined:**
  - A 3-bit counter increments on each cycle where `instr_rd_req`=1 and the instruction port is not granted, and clears on an I grant.
  - When the counter reaches `STARVE_LIMIT`, the next cycle grants I even if data is requesting. The data request is denied that cycle (no success) and must be held.
- **Undefined:** strict data priority; the counter logic is absent.

## Test plan

1. **Single instruction read.** Reset; memory[0x0123]=0xBEEF; `instr_rd_req`=1, `instr_address`=0x0123 for one cycle -> at cycle +2, `instr_success`=1, `instr_requested_address`=0x0123, `instr_data`=0xBEEF; `will_queue`=1 in the request cycle.
2. **Streaming fill.** `instr_address` 0x0100..0x010F, one per cycle -> 16 consecutive `instr_success` pulses starting at cycle +2 with matching addresses and data.
3. **Collision.** `data_rd_req` to 0x0200 and `instr_rd_req` to 0x0300 in the same cycle -> `will_queue`=0, data success at +2 with memory[0x0200], no instruction success. The held instruction request is granted the next cycle and succeeds at +3.
4. **Masked write then read.** Memory[0x0010]=0x1234; write 0xABCD with mask 2'b01 -> `data_success` at +2; a subsequent read returns 0x12CD.
5. **Reset mid-flight.** Grant instruction reads at cycles 0 and 1; assert `RST` at cycle 1 -> no `instr_success` at cycles 2 and 3; all outputs are 0.
6. **Starvation guard (macro defined, `STARVE_LIMIT`=4).** Continuous data requests plus `instr_rd_req` -> forced I grant in the fifth cycle, `instr_success` two cycles later; the data request in that cycle receives no success. Macro undefined: no instruction success over 32 cycles.
